sprite_table_ahb_reader: RTL

//  AHB-Lite read responder for the sprite table. Pairs with the write-snooping sprite table decoder.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_shadow_ram.sv | 27 ++
 rtl/sprite_table_ahb_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite table AHB read responder.
// Status word layout lives here so bus and video sides agree on it.
package sprite_pkg;

  localparam logic [31:0] SPRITE_TABLE_BASE = 32'h1F80_0000;
  localparam int          SPRITE_IDX_W      = 9;
  localparam logic [11:0] STATUS_OFFSET     = 12'h800;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR_DATA = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RD_DATA = 2'd3;

  function automatic logic [31:0] status_word(
    input logic [15:0] frames,
    input logic [11:0] row,
    input logic [11:0] vb_row
  );
    return {frames, 3'b000, row >= vb_row, row};
  endfunction

endpackage

// File: rtl/sprite_shadow_ram.sv
// Shadow copy of the sprite table: one write port, one registered read port.
// No reset so the array maps onto a block RAM.
module sprite_shadow_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // read-first: a same-cycle write is not visible on rdata
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_table_ahb_reader.sv
// AHB-Lite read responder mirroring CPU writes to the sprite table.
// Define SPRITE_READER_STATUS_EN for the status/frame counter word.
module sprite_table_ahb_reader
  import sprite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SPRITE_TABLE_BASE,
  parameter int          TABLE_WORDS = 512,
  parameter logic [11:0] ROW_VBLANK  = 12'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [11:0] pix_row,
  input  logic [11:0] pix_col,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        ahb_sel
);

  localparam logic [SPRITE_IDX_W:0] DEPTH =
    TABLE_WORDS[SPRITE_IDX_W:0];

  logic [1:0]              state;
  logic [1:0]              state_nx;
  logic [SPRITE_IDX_W-1:0] idx;
  logic [SPRITE_IDX_W-1:0] idx_q;
  logic                    tbl_hit;
  logic                    stat_hit;
  logic                    hit;
  logic                    accept;
  logic                    oor;
  logic                    oor_q;
  logic                    stat_q;
  logic                    fwd_q;
  logic                    we;
  logic                    re;
  logic [31:0]             fwd_data;
  logic [31:0]             ram_q;
  logic [31:0]             status;
  logic [31:0]             rd_word;
  logic                    unused;

  assign unused = ^{HADDR[1:0], pix_row, pix_col};

  assign idx     = HADDR[10:2];
  assign oor     = {1'b0, idx} >= DEPTH;
  assign tbl_hit = HTRANS[1] && HREADY &&
                   HADDR[31:11] == BASE_ADDR[31:11];

`ifdef SPRITE_READER_STATUS_EN
  localparam logic [31:0] STATUS_ADDR =
    BASE_ADDR + {20'd0, STATUS_OFFSET};

  logic [15:0] frame_cnt;

  assign stat_hit = HTRANS[1] && HREADY &&
                    HADDR[31:2] == STATUS_ADDR[31:2];
  assign status   = status_word(frame_cnt, pix_row, ROW_VBLANK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (pix_row == ROW_VBLANK && pix_col == '0)
      frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign stat_hit = 1'b0;
  assign status   = '0;
`endif

  assign hit       = tbl_hit || stat_hit;
  assign accept    = hit && state != S_RD_WAIT;
  assign HREADYOUT = state != S_RD_WAIT;
  assign HRESP     = 1'b0;

  // status word and out-of-range slots swallow writes
  assign we = state == S_WR_DATA && !oor_q && !stat_q;
  assign re = accept && !HWRITE;

  sprite_shadow_ram #(
    .DEPTH (TABLE_WORDS),
    .AW    (SPRITE_IDX_W),
    .W     (32)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (HWDATA),
    .re    (re),
    .raddr (idx),
    .rdata (ram_q)
  );

  always_comb begin
    state_nx = S_IDLE;
    if (accept)
      state_nx = HWRITE ? S_WR_DATA : S_RD_WAIT;
    else if (state == S_RD_WAIT)
      state_nx = S_RD_DATA;
  end

  always_comb begin
    rd_word = ram_q;
    if (fwd_q)
      rd_word = fwd_data;
    if (stat_q)
      rd_word = status;
    if (oor_q)
      rd_word = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ahb_sel  <= 1'b0;
      HRDATA   <= '0;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      stat_q   <= 1'b0;
      fwd_q    <= 1'b0;
      fwd_data <= '0;
    end else begin
      state  <= state_nx;
      HRDATA <= (state == S_RD_WAIT) ? rd_word : '0;
      if (accept) begin
        ahb_sel  <= 1'b1;
        idx_q    <= idx;
        oor_q    <= oor && !stat_hit;
        stat_q   <= stat_hit;
        // RAM read lands before this write does
        fwd_q    <= we && idx_q == idx;
        fwd_data <= HWDATA;
      end else if (state != S_RD_WAIT) begin
        ahb_sel  <= 1'b0;
      end
    end
  end

endmodule
